bsg_cam_1r1w_arb: RTL and testbench

- Sequencer/arbiter placed in front of one bsg_cam_1r1w_sync instance.
- Shares the CAM's single read port between num_req_p lookup requesters using round-robin arbitration.
- Sequences writes and nukes from one writer, blocking read/write tag hazards and stale reads around a nuke.
- Routes the 1-cycle-latency read result back to the granted requester and keeps saturating lookup/hit counters.

---
 rtl/bsg_cam_1r1w_arb.sv | 168 ++++++++++++++++
 tb/tb_bsg_cam_1r1w_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cam_1r1w_arb.sv
// bsg_cam_1r1w_arb
// Front-end sequencer for a single bsg_cam_1r1w_sync: round-robin sharing of
// the CAM read port among num_req_p requesters, write/nuke sequencing with
// read-after-write tag hazard blocking, a two-cycle read quiet period after a
// nuke, one-hot response routing and saturating lookup/hit counters.
module bsg_cam_1r1w_arb #(
    parameter int num_req_p    = 4,
    parameter int tag_width_p  = 8,
    parameter int data_width_p = 16,
    parameter int ctr_width_p  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [num_req_p-1:0]             rd_v_i,
    input  logic [num_req_p*tag_width_p-1:0] rd_tag_i,
    output logic [num_req_p-1:0]             rd_ready_o,
    output logic [num_req_p-1:0]             resp_v_o,
    output logic                             resp_hit_o,
    output logic [data_width_p-1:0]          resp_data_o,
    input  logic                             wr_v_i,
    input  logic                             wr_nuke_i,
    input  logic [tag_width_p-1:0]           wr_tag_i,
    input  logic [data_width_p-1:0]          wr_data_i,
    output logic                             wr_ready_o,
    output logic                             cam_w_v_o,
    output logic                             cam_w_nuke_o,
    output logic [tag_width_p-1:0]           cam_w_tag_o,
    output logic [data_width_p-1:0]          cam_w_data_o,
    output logic                             cam_r_v_o,
    output logic [tag_width_p-1:0]           cam_r_tag_o,
    input  logic [data_width_p-1:0]          cam_r_data_i,
    input  logic                             cam_r_v_i,
    input  logic                             clear_ctrs_i,
    output logic [ctr_width_p-1:0]           lookups_o,
    output logic [ctr_width_p-1:0]           hits_o
);

    localparam int ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        NUKE   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    state_e                  r_state;
    logic [ptr_w_lp-1:0]     r_ptr;
    logic [num_req_p-1:0]    r_resp_v;
    logic [ctr_width_p-1:0]  r_lookups;
    logic [ctr_width_p-1:0]  r_hits;

    logic                    w_run;
    logic                    w_found;
    logic [ptr_w_lp-1:0]     w_win;
    logic [tag_width_p-1:0]  w_win_tag;
    logic                    w_hazard;
    logic                    w_grant;
    logic [num_req_p-1:0]    w_grant_oh;
    logic                    w_wr_acc;
    logic                    w_resp_any;

    // Readers and writer are only serviced in RUN and never while reset is held.
    assign w_run = (r_state == RUN) && reset;

    // Round-robin search: first valid requester at or above the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            idx = (idx >= num_req_p) ? (idx - num_req_p) : idx;
            if (!w_found && rd_v_i[idx]) begin
                w_found = 1'b1;
                w_win   = idx[ptr_w_lp-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_win_tag  = rd_tag_i[w_win*tag_width_p +: tag_width_p];

    // A read is held off while a nuke is pending or the writer targets the same tag.
    assign w_hazard   = wr_v_i && (wr_nuke_i || (wr_tag_i == w_win_tag));
    assign w_grant    = w_run && w_found && !w_hazard;
    assign w_grant_oh = w_grant ? ({{(num_req_p-1){1'b0}}, 1'b1} << w_win) : '0;
    assign w_wr_acc   = w_run && wr_v_i;

    assign rd_ready_o   = w_grant_oh;
    assign cam_r_v_o    = w_grant;
    assign cam_r_tag_o  = w_grant ? w_win_tag : '0;
    assign wr_ready_o   = w_run;
    assign cam_w_v_o    = w_wr_acc;
    assign cam_w_nuke_o = w_wr_acc && wr_nuke_i;
    assign cam_w_tag_o  = wr_tag_i;
    assign cam_w_data_o = wr_data_i;

    // CAM read data arrives the cycle after the grant; route it to the registered index.
    assign w_resp_any  = |r_resp_v;
    assign resp_v_o    = r_resp_v;
    assign resp_hit_o  = w_resp_any && cam_r_v_i;
    assign resp_data_o = w_resp_any ? cam_r_data_i : '0;

    assign lookups_o = r_lookups;
    assign hits_o    = r_hits;

    // Sequencer: an accepted nuke blocks both ports for NUKE and SETTLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     r_state <= (w_wr_acc && wr_nuke_i) ? NUKE : RUN;
                NUKE:    r_state <= SETTLE;
                SETTLE:  r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // Round-robin pointer moves just past the winner on each grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == ptr_w_lp'(num_req_p - 1)) ? '0 : (w_win + ptr_w_lp'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Registered grant index drives the one-hot response strobe next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_v <= '0;
        end else begin
            r_resp_v <= w_grant_oh;
        end
    end

    // Saturating lookup counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lookups <= '0;
        end else if (clear_ctrs_i) begin
            r_lookups <= '0;
        end else if (w_grant && (r_lookups != {ctr_width_p{1'b1}})) begin
            r_lookups <= r_lookups + ctr_width_p'(1);
        end else begin
            r_lookups <= r_lookups;
        end
    end

    // Saturating hit counter; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hits <= '0;
        end else if (clear_ctrs_i) begin
            r_hits <= '0;
        end else if (resp_hit_o && (r_hits != {ctr_width_p{1'b1}})) begin
            r_hits <= r_hits + ctr_width_p'(1);
        end else begin
            r_hits <= r_hits;
        end
    end

endmodule

// File: tb/tb_bsg_cam_1r1w_arb.sv
// Bench for bsg_cam_1r1w_arb: behavioural CAM on the DUT's CAM ports, an
// independent reference model of arbitration/sequencing/counters, and a
// scoreboard queue of expected responses popped when the response is due.
module tb_bsg_cam_1r1w_arb;

    localparam int NR = 4;
    localparam int TW = 8;
    localparam int DW = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   rd_v;
    logic [NR*TW-1:0] rd_tag;
    logic [NR-1:0]   rd_ready;
    logic [NR-1:0]   resp_v;
    logic            resp_hit;
    logic [DW-1:0]   resp_data;
    logic            wr_v, wr_nuke;
    logic [TW-1:0]   wr_tag;
    logic [DW-1:0]   wr_data;
    logic            wr_ready;
    logic            cam_w_v, cam_w_nuke;
    logic [TW-1:0]   cam_w_tag;
    logic [DW-1:0]   cam_w_data;
    logic            cam_r_v;
    logic [TW-1:0]   cam_r_tag;
    bit   [DW-1:0]   cam_r_data_b;
    bit              cam_r_v_b;
    logic            clr;
    logic [CW-1:0]   lookups, hits;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [NR-1:0] v;
        logic          hit;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    // reference model state
    bit   [255:0] ref_vld;
    logic [DW-1:0] ref_data [256];
    int ptr_m = 0;
    int st_m  = 0;
    int lk_m  = 0;
    int ht_m  = 0;

    // behavioural CAM environment
    bit          env_vld  [256];
    bit [DW-1:0] env_data [256];

    always #5 clk = ~clk;

    bsg_cam_1r1w_arb #(
        .num_req_p(NR), .tag_width_p(TW), .data_width_p(DW), .ctr_width_p(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_v_i(rd_v), .rd_tag_i(rd_tag), .rd_ready_o(rd_ready),
        .resp_v_o(resp_v), .resp_hit_o(resp_hit), .resp_data_o(resp_data),
        .wr_v_i(wr_v), .wr_nuke_i(wr_nuke), .wr_tag_i(wr_tag), .wr_data_i(wr_data),
        .wr_ready_o(wr_ready),
        .cam_w_v_o(cam_w_v), .cam_w_nuke_o(cam_w_nuke), .cam_w_tag_o(cam_w_tag),
        .cam_w_data_o(cam_w_data),
        .cam_r_v_o(cam_r_v), .cam_r_tag_o(cam_r_tag),
        .cam_r_data_i(cam_r_data_b), .cam_r_v_i(cam_r_v_b),
        .clear_ctrs_i(clr), .lookups_o(lookups), .hits_o(hits)
    );

    // CAM: 1-cycle read of pre-write contents, write/nuke at the edge.
    always @(posedge clk) begin
        cam_r_v_b    <= cam_r_v && env_vld[cam_r_tag];
        cam_r_data_b <= (cam_r_v && env_vld[cam_r_tag]) ? env_data[cam_r_tag] : '0;
        if (cam_w_v) begin
            if (cam_w_nuke) begin
                for (int i = 0; i < 256; i++) env_vld[i] <= 1'b0;
            end else begin
                env_vld[cam_w_tag]  <= 1'b1;
                env_data[cam_w_tag] <= cam_w_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        rd_v = '0; rd_tag = '0; wr_v = 1'b0; wr_nuke = 1'b0;
        wr_tag = '0; wr_data = '0; clr = 1'b0;
    endtask

    task automatic set_tags(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                            input logic [TW-1:0] t2, input logic [TW-1:0] t3);
        rd_tag = {t3, t2, t1, t0};
    endtask

    // One clock: check response/grant/counters at negedge, then step the model.
    task automatic run_cycle();
        exp_t e;
        bit found, hit_now;
        int g, idx;
        logic [TW-1:0] t;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("resp_v", resp_v, e.v);
            chk("resp_hit", resp_hit, e.hit);
            chk("resp_data", resp_data, e.data);
            hit_now = e.hit;
        end else begin
            chk("resp_idle", resp_v, 0);
            hit_now = 1'b0;
        end
        found = 1'b0; g = 0;
        if (st_m == 0) begin
            for (int k = 0; k < NR; k++) begin
                idx = (ptr_m + k) % NR;
                if (!found && rd_v[idx]) begin found = 1'b1; g = idx; end
            end
        end
        t = rd_tag[g*TW +: TW];
        if (found && wr_v && (wr_nuke || wr_tag == t)) found = 1'b0;
        chk("rd_ready", rd_ready, found ? (32'd1 << g) : 32'd0);
        chk("wr_ready", wr_ready, st_m == 0);
        chk("cam_w_v", cam_w_v, (st_m == 0) && wr_v);
        chk("cam_r_v", cam_r_v, found);
        chk("lookups", lookups, lk_m);
        chk("hits", hits, ht_m);
        if (found) begin
            chk("cam_r_tag", cam_r_tag, t);
            sb_q.push_back('{v: NR'(1) << g, hit: ref_vld[t],
                             data: ref_vld[t] ? ref_data[t] : '0});
        end
        @(posedge clk);
        if (found) ptr_m = (g + 1) % NR;
        if (clr) lk_m = 0;
        else if (found && lk_m < 15) lk_m++;
        if (clr) ht_m = 0;
        else if (hit_now && ht_m < 15) ht_m++;
        case (st_m)
            0: if (wr_v) begin
                   if (wr_nuke) begin ref_vld = '0; st_m = 1; end
                   else begin ref_vld[wr_tag] = 1'b1; ref_data[wr_tag] = wr_data; end
               end
            1: st_m = 2;
            default: st_m = 0;
        endcase
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        rd_v = 4'b1111;
        wr_v = 1'b1;
        // reset state with requests pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_cam_w_v", cam_w_v, 0);
        chk("rst_cam_r_v", cam_r_v, 0);
        chk("rst_resp_v", resp_v, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_lookups", lookups, 0);
        chk("rst_hits", hits, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        set_idle();

        // writes 00/dead, 11/beef, then requester 2 hits 11
        wr_v = 1'b1; wr_tag = 8'h00; wr_data = 16'hdead; run_cycle();
        wr_tag = 8'h11; wr_data = 16'hbeef; run_cycle();
        set_idle();
        rd_v = 4'b0100; set_tags(8'h00, 8'h00, 8'h11, 8'h00); run_cycle();
        set_idle(); run_cycle();
        // bring pointer back to 0 and clear counters
        rd_v = 4'b1000; run_cycle();
        set_idle(); clr = 1'b1; run_cycle();
        clr = 1'b0;

        // all four requesters for 8 cycles
        rd_v = 4'b1111; set_tags(8'h00, 8'h11, 8'h22, 8'h33);
        repeat (8) run_cycle();
        set_idle(); run_cycle();
        chk("lookups_8", lookups, 8);

        // same-tag hazard: blocked, then granted, sees the new data
        wr_v = 1'b1; wr_tag = 8'h11; wr_data = 16'h1234;
        rd_v = 4'b0001; set_tags(8'h11, 8'h00, 8'h00, 8'h00); run_cycle();
        wr_v = 1'b0; run_cycle();
        set_idle(); run_cycle();

        // nuke with everybody waiting: grants resume three cycles later
        rd_v = 4'b1111; set_tags(8'h00, 8'h00, 8'h00, 8'h00);
        wr_v = 1'b1; wr_nuke = 1'b1; run_cycle();
        wr_v = 1'b0; wr_nuke = 1'b0;
        repeat (4) run_cycle();
        set_idle(); run_cycle();

        // miss on 55
        rd_v = 4'b0010; set_tags(8'h00, 8'h55, 8'h00, 8'h00); run_cycle();
        set_idle(); run_cycle();

        // saturation: 20 hits on 00
        clr = 1'b1; wr_v = 1'b1; wr_tag = 8'h00; wr_data = 16'hdead; run_cycle();
        set_idle();
        rd_v = 4'b1111; set_tags(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (20) run_cycle();
        set_idle(); run_cycle();
        chk("hits_sat", hits, 4'hF);
        chk("lookups_sat", lookups, 4'hF);

        // clear coinciding with a hit response
        rd_v = 4'b0001; run_cycle();
        set_idle(); clr = 1'b1; run_cycle();
        clr = 1'b0; run_cycle();
        chk("hits_clr", hits, 0);

        // reset while a response is in flight
        rd_v = 4'b0100; set_tags(8'h00, 8'h00, 8'h00, 8'h00); run_cycle();
        set_idle();
        reset = 1'b0;
        #1;
        chk("midrst_resp_v", resp_v, 0);
        chk("midrst_resp_hit", resp_hit, 0);
        sb_q.delete();
        ptr_m = 0; st_m = 0; lk_m = 0; ht_m = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        rd_v = 4'b1111; run_cycle();
        set_idle(); run_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
